// File: rtl/msp430_trace_pkg.sv
// Shared types for the MSP430 retired-instruction trace consumer.
// Event codes, the queued event record and the marker opcode.
package msp430_trace_pkg;

   typedef enum logic [3:0] {
      EV_NONE      = 4'd0,
      EV_EXIT      = 4'd1,
      EV_TRACE_ON  = 4'd2,
      EV_TRACE_OFF = 4'd3,
      EV_PUTC      = 4'd4,
      EV_REPORT    = 4'd5
   } ev_code_t;

   typedef struct packed {
      logic [3:0]  code;
      logic [31:0] data;
      logic [31:0] pc;
      logic [15:0] id;
   } trace_event_t;

   localparam logic [11:0] EVT_OPC_DEFAULT = 12'h430;

   // Only codes 1..5 are meaningful; 0 is a plain NOP marker
   function automatic logic is_known_code(input logic [3:0] c);
      return (c >= EV_EXIT) && (c <= EV_REPORT);
   endfunction

endpackage

// File: rtl/msp430_trace_event_fifo.sv
// Synchronous show-ahead FIFO of trace event records.
// Wrap-bit pointers; a pop in the same cycle lets a full FIFO accept a push.
module msp430_trace_event_fifo
   import msp430_trace_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  trace_event_t din,
   output trace_event_t dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   trace_event_t mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Head is masked to zero when empty so outputs are clean after reset
   assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update; reset flushes the queue
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents are meaningless until the pointers cover them
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/msp430_trace_event_decoder.sv
// Per-core trace consumer: r3 shadow, marker decode, event queue,
// exit latch, dropped-event counter and all-cores-done flag.
module msp430_trace_event_decoder
   import msp430_trace_pkg::*;
#(
   parameter logic [15:0] ID         = 16'd0,
   parameter int          NUM_CORES  = 4,
   parameter logic [11:0] EVT_OPC    = EVT_OPC_DEFAULT,
   parameter int          FIFO_DEPTH = 8,
   parameter int          DROP_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tr_valid,
   input  logic [31:0]          tr_pc,
   input  logic [15:0]          tr_insn,
   input  logic                 tr_wben,
   input  logic [4:0]           tr_wbreg,
   input  logic [31:0]          tr_wbdata,
   output logic                 ev_valid,
   input  logic                 ev_ready,
   output logic [3:0]           ev_code,
   output logic [31:0]          ev_data,
   output logic [31:0]          ev_pc,
   output logic [15:0]          ev_id,
   output logic                 termination,
   output logic [31:0]          exit_code,
   input  logic [NUM_CORES-1:0] termination_all,
   output logic                 all_done,
   output logic [DROP_W-1:0]    drop_cnt
);

   logic [31:0]  r3;
   logic         detect;
   logic         is_exit;
   logic         pop;
   logic         full;
   logic         empty;
   logic         drop;
   trace_event_t din;
   trace_event_t head;

   assign detect  = tr_valid && (tr_insn[15:4] == EVT_OPC) &&
                    is_known_code(tr_insn[3:0]);
   assign is_exit = detect && (tr_insn[3:0] == EV_EXIT);
   assign pop     = ev_valid && ev_ready;
   assign drop    = detect && full && !pop;

   // Event carries the r3 value seen before this record's writeback
   assign din = '{code: tr_insn[3:0], data: r3, pc: tr_pc, id: ID};

   msp430_trace_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (detect),
      .pop   (pop),
      .din   (din),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   assign ev_valid = !empty;
   assign ev_code  = head.code;
   assign ev_data  = head.data;
   assign ev_pc    = head.pc;
   assign ev_id    = head.id;

   // Shadow r3 from the writeback stream
   always_ff @(posedge clk) begin
      if (rst) begin
         r3 <= '0;
      end else if (tr_valid && tr_wben && tr_wbreg == 5'd3) begin
         r3 <= tr_wbdata;
      end
   end

   // Latch the first exit; independent of FIFO space
   always_ff @(posedge clk) begin
      if (rst) begin
         termination <= 1'b0;
         exit_code   <= '0;
      end else if (is_exit && !termination) begin
         termination <= 1'b1;
         exit_code   <= r3;
      end
   end

   // Count events lost to a full queue, saturating
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (drop && drop_cnt != {DROP_W{1'b1}}) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

   // Registered AND of every core's termination flag
   always_ff @(posedge clk) begin
      if (rst) begin
         all_done <= 1'b0;
      end else begin
         all_done <= &termination_all;
      end
   end

endmodule

// File: tb/tb_msp430_trace_event_decoder.sv
// Self-checking bench for msp430_trace_event_decoder.
// Queue-based reference model, directed scenarios then random traffic.
module tb_msp430_trace_event_decoder;

   localparam int DEPTH = 8;
   localparam logic [15:0] TB_ID = 16'h00A5;

   logic        clk = 1'b0;
   logic        rst;
   logic        tr_valid;
   logic [31:0] tr_pc;
   logic [15:0] tr_insn;
   logic        tr_wben;
   logic [4:0]  tr_wbreg;
   logic [31:0] tr_wbdata;
   logic        ev_valid;
   logic        ev_ready;
   logic [3:0]  ev_code;
   logic [31:0] ev_data;
   logic [31:0] ev_pc;
   logic [15:0] ev_id;
   logic        termination;
   logic [31:0] exit_code;
   logic [3:0]  termination_all;
   logic        all_done;
   logic [7:0]  drop_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  code;
      logic [31:0] data;
      logic [31:0] pc;
   } mev_t;

   mev_t        q[$];
   logic [31:0] m_r3;
   logic        m_term;
   logic [31:0] m_exit;
   int          m_drop;
   logic        m_done;

   always #5 clk = ~clk;

   msp430_trace_event_decoder #(
      .ID         (TB_ID),
      .NUM_CORES  (4),
      .EVT_OPC    (12'h430),
      .FIFO_DEPTH (DEPTH),
      .DROP_W     (8)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .tr_valid        (tr_valid),
      .tr_pc           (tr_pc),
      .tr_insn         (tr_insn),
      .tr_wben         (tr_wben),
      .tr_wbreg        (tr_wbreg),
      .tr_wbdata       (tr_wbdata),
      .ev_valid        (ev_valid),
      .ev_ready        (ev_ready),
      .ev_code         (ev_code),
      .ev_data         (ev_data),
      .ev_pc           (ev_pc),
      .ev_id           (ev_id),
      .termination     (termination),
      .exit_code       (exit_code),
      .termination_all (termination_all),
      .all_done        (all_done),
      .drop_cnt        (drop_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [3:0]  c;
      logic [31:0] d;
      logic [31:0] p;
      logic [15:0] i;
      c = '0; d = '0; p = '0; i = '0;
      if (q.size() > 0) begin
         c = q[0].code; d = q[0].data; p = q[0].pc; i = TB_ID;
      end
      chk("ev_valid", {31'd0, ev_valid}, {31'd0, q.size() != 0});
      chk("ev_code", {28'd0, ev_code}, {28'd0, c});
      chk("ev_data", ev_data, d);
      chk("ev_pc", ev_pc, p);
      chk("ev_id", {16'd0, ev_id}, {16'd0, i});
      chk("termination", {31'd0, termination}, {31'd0, m_term});
      chk("exit_code", exit_code, m_exit);
      chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
      chk("all_done", {31'd0, all_done}, {31'd0, m_done});
   endtask

   task automatic cycle(input logic v, input logic [31:0] pc,
                        input logic [15:0] insn, input logic wb,
                        input logic [4:0] wreg, input logic [31:0] d,
                        input logic rdy);
      logic det;
      tr_valid = v; tr_pc = pc; tr_insn = insn;
      tr_wben = wb; tr_wbreg = wreg; tr_wbdata = d;
      ev_ready = rdy;
      det = v && insn[15:4] == 12'h430 &&
            insn[3:0] >= 4'd1 && insn[3:0] <= 4'd5;
      if (rdy && q.size() > 0) q.delete(0);
      if (det) begin
         if (insn[3:0] == 4'd1 && !m_term) begin
            m_term = 1'b1;
            m_exit = m_r3;
         end
         if (q.size() < DEPTH) q.push_back('{insn[3:0], m_r3, pc});
         else if (m_drop < 255) m_drop++;
      end
      if (v && wb && wreg == 5'd3) m_r3 = d;
      m_done = &termination_all;
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      m_r3 = '0; m_term = 1'b0; m_exit = '0; m_drop = 0; m_done = 1'b0;
      check_all();
   endtask

   task automatic idle(input logic rdy);
      cycle(1'b0, 32'd0, 16'd0, 1'b0, 5'd0, 32'd0, rdy);
   endtask

   task automatic set_r3(input logic [31:0] v);
      cycle(1'b1, 32'h500, 16'h4403, 1'b1, 5'd3, v, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      tr_valid = 1'b0; tr_pc = '0; tr_insn = '0;
      tr_wben = 1'b0; tr_wbreg = '0; tr_wbdata = '0;
      ev_ready = 1'b0;
      termination_all = 4'b0000;
      do_reset();

      // putc with r3=0x41, then pop
      set_r3(32'h41);
      cycle(1'b1, 32'h20, 16'h4304, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("putc_valid", {31'd0, ev_valid}, 32'd1);
      chk("putc_code", {28'd0, ev_code}, 32'd4);
      chk("putc_data", ev_data, 32'h41);
      chk("putc_pc", ev_pc, 32'h20);
      idle(1'b1);
      chk("putc_popped", {31'd0, ev_valid}, 32'd0);

      // pre-write r3 value is reported
      set_r3(32'h10);
      cycle(1'b1, 32'h30, 16'h4305, 1'b1, 5'd3, 32'h99, 1'b0);
      chk("prewrite_data", ev_data, 32'h10);
      cycle(1'b1, 32'h32, 16'h4305, 1'b0, 5'd0, 32'd0, 1'b1);
      chk("postwrite_data", ev_data, 32'h99);
      idle(1'b1);

      // overflow: 10 pushes into 8 slots
      do_reset();
      set_r3(32'h55);
      for (int i = 0; i < 10; i++)
         cycle(1'b1, 32'h100 + 2 * i, 16'h4304, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("overflow_drop", {24'd0, drop_cnt}, 32'd2);

      // full with simultaneous push and pop
      cycle(1'b1, 32'h200, 16'h4304, 1'b0, 5'd0, 32'd0, 1'b1);
      chk("pushpop_drop", {24'd0, drop_cnt}, 32'd2);
      chk("pushpop_head", ev_pc, 32'h102);

      // exit on full FIFO, then a second exit
      set_r3(32'h7);
      cycle(1'b1, 32'h300, 16'h4301, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("exit_term", {31'd0, termination}, 32'd1);
      chk("exit_code", exit_code, 32'h7);
      chk("exit_drop", {24'd0, drop_cnt}, 32'd3);
      set_r3(32'h9);
      cycle(1'b1, 32'h302, 16'h4301, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("exit2_code", exit_code, 32'h7);

      // drain and confirm order via the model
      for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
      chk("drained", {31'd0, ev_valid}, 32'd0);

      // all-cores-done
      termination_all = 4'b0111;
      idle(1'b0);
      chk("all_done_0111", {31'd0, all_done}, 32'd0);
      termination_all = 4'b1111;
      idle(1'b0);
      chk("all_done_1111", {31'd0, all_done}, 32'd1);
      termination_all = 4'b0000;
      idle(1'b0);

      // reset while three events are queued
      set_r3(32'h33);
      cycle(1'b1, 32'h400, 16'h4304, 1'b0, 5'd0, 32'd0, 1'b0);
      cycle(1'b1, 32'h402, 16'h4301, 1'b0, 5'd0, 32'd0, 1'b0);
      cycle(1'b1, 32'h404, 16'h4305, 1'b0, 5'd0, 32'd0, 1'b0);
      termination_all = 4'b1111;
      idle(1'b0);
      termination_all = 4'b0000;
      tr_valid = 1'b1; tr_insn = 16'h4304; tr_pc = 32'h406;
      do_reset();
      chk("rst_valid", {31'd0, ev_valid}, 32'd0);
      chk("rst_term", {31'd0, termination}, 32'd0);
      chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
      cycle(1'b1, 32'h408, 16'h4304, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("rst_r3", ev_data, 32'd0);
      idle(1'b1);

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         logic [15:0] insn;
         logic [4:0]  wreg;
         if ($urandom_range(0, 3) != 0)
            insn = 16'h4300 | 16'($urandom_range(0, 15));
         else
            insn = 16'($urandom);
         wreg = 5'($urandom_range(0, 5));
         if ($urandom_range(0, 15) == 0)
            termination_all = 4'($urandom);
         cycle(1'($urandom_range(0, 1)), $urandom, insn,
               1'($urandom_range(0, 1)), wreg, $urandom,
               $urandom_range(0, 2) == 0);
         if ($urandom_range(0, 199) == 0) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
